// File: rtl/touch_frame_lock.sv
// touch_frame_lock
//   Sits between touchpad_controller and tft_driver. It qualifies raw touch
//   samples by pressure, debounces press/release, block-averages
//   2**AVG_LOG2 samples, maps the average to screen coordinates, and hands
//   new coordinates to the TFT only on new_frame.
// Ports
//   cclk          system clock
//   reset         synchronous, active-high
//   touch_valid   1-cycle strobe: touch_x/y/z hold a fresh sample
//   touch_x/y/z   raw 12-bit samples (z = pressure)
//   new_frame     1-cycle strobe at the frame boundary
//   locked_x/y    screen coordinates, stable for the whole frame
//   locked_valid  locked_x/y hold a real touch
//   press_event   1-cycle pulse when locked_valid rises
//   release_event 1-cycle pulse when locked_valid falls
module touch_frame_lock #(
    parameter int unsigned X_OFFSET      = 150,
    parameter int unsigned Y_OFFSET      = 300,
    parameter int unsigned X_SHIFT       = 3,
    parameter int unsigned Y_SHIFT       = 4,
    parameter int unsigned X_MAX         = 479,
    parameter int unsigned Y_MAX         = 271,
    parameter int unsigned Z_THRESH      = 256,
    parameter int unsigned PRESS_COUNT   = 4,
    parameter int unsigned RELEASE_COUNT = 4,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned NO_TOUCH      = 1000
) (
    input  logic        cclk,
    input  logic        reset,
    input  logic        touch_valid,
    input  logic [11:0] touch_x,
    input  logic [11:0] touch_y,
    input  logic [11:0] touch_z,
    input  logic        new_frame,
    output logic [11:0] locked_x,
    output logic [11:0] locked_y,
    output logic        locked_valid,
    output logic        press_event,
    output logic        release_event
);

    localparam int unsigned AW   = 12 + AVG_LOG2;
    localparam int unsigned WW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned CMAX = (PRESS_COUNT > RELEASE_COUNT) ? PRESS_COUNT : RELEASE_COUNT;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [11:0] XOFF  = 12'(X_OFFSET);
    localparam logic [11:0] YOFF  = 12'(Y_OFFSET);
    localparam logic [11:0] XMAXV = 12'(X_MAX);
    localparam logic [11:0] YMAXV = 12'(Y_MAX);
    localparam logic [11:0] NT    = 12'(NO_TOUCH);

    typedef enum logic [1:0] {RELEASED, PRESSING, TOUCHING, RELEASING} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [WW-1:0]   win_q, win_d;
    logic            ready_q, ready_d;
    logic [11:0]     pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [11:0]     lock_x_q, lock_x_d, lock_y_q, lock_y_d;
    logic            lv_q, lv_d, pe_q, pe_d, re_q, re_d;

    logic            pressed, win_last, touching;
    logic [AW-1:0]   sum_x, sum_y;
    logic [CW-1:0]   cnt_inc;

    // Offset with saturation at zero, shift, then clamp to the panel edge.
    function automatic logic [11:0] to_screen(input logic [11:0] avg, input logic [11:0] off,
                                              input int unsigned sh, input logic [11:0] mx);
        logic [11:0] d;
        d = (avg > off) ? ((avg - off) >> sh) : '0;
        return (d > mx) ? mx : d;
    endfunction

    assign pressed  = (touch_z >= 12'(Z_THRESH));
    assign win_last = (win_q == WW'((1 << AVG_LOG2) - 1));
    assign sum_x    = acc_x_q + AW'(touch_x);
    assign sum_y    = acc_y_q + AW'(touch_y);
    assign cnt_inc  = cnt_q + CW'(1);
    assign touching = ((state_q == TOUCHING) || (state_q == RELEASING)) && ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        win_d    = win_q;
        ready_d  = ready_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        lock_x_d = lock_x_q;
        lock_y_d = lock_y_q;
        lv_d     = lv_q;
        pe_d     = 1'b0;
        re_d     = 1'b0;

        if (touch_valid) begin
            if (pressed) begin
                unique case (state_q)
                    RELEASED: begin
                        state_d = (PRESS_COUNT == 1) ? TOUCHING : PRESSING;
                        cnt_d   = (PRESS_COUNT == 1) ? '0 : CW'(1);
                    end
                    PRESSING: begin
                        if (cnt_inc >= CW'(PRESS_COUNT)) begin
                            state_d = TOUCHING;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    RELEASING: begin
                        state_d = TOUCHING;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase

                if (win_last) begin
                    pend_x_d = to_screen(sum_x[AVG_LOG2 +: 12], XOFF, X_SHIFT, XMAXV);
                    pend_y_d = to_screen(sum_y[AVG_LOG2 +: 12], YOFF, Y_SHIFT, YMAXV);
                    ready_d  = 1'b1;
                    acc_x_d  = '0;
                    acc_y_d  = '0;
                    win_d    = '0;
                end else begin
                    acc_x_d = sum_x;
                    acc_y_d = sum_y;
                    win_d   = win_q + WW'(1);
                end
            end else begin
                acc_x_d = '0;
                acc_y_d = '0;
                win_d   = '0;
                unique case (state_q)
                    PRESSING: begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end
                    TOUCHING: begin
                        if (RELEASE_COUNT == 1) begin
                            state_d = RELEASED;
                            cnt_d   = '0;
                            ready_d = 1'b0;
                        end else begin
                            state_d = RELEASING;
                            cnt_d   = CW'(1);
                        end
                    end
                    RELEASING: begin
                        if (cnt_inc >= CW'(RELEASE_COUNT)) begin
                            state_d = RELEASED;
                            cnt_d   = '0;
                            ready_d = 1'b0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Frame update looks only at pre-edge state, so a coincident sample
        // shows up at the following frame.
        if (new_frame) begin
            lock_x_d = touching ? pend_x_q : NT;
            lock_y_d = touching ? pend_y_q : NT;
            lv_d     = touching;
            pe_d     = touching && !lv_q;
            re_d     = !touching && lv_q;
        end
    end

    always_ff @(posedge cclk) begin
        if (reset) begin
            state_q  <= RELEASED;
            cnt_q    <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            win_q    <= '0;
            ready_q  <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            lock_x_q <= NT;
            lock_y_q <= NT;
            lv_q     <= 1'b0;
            pe_q     <= 1'b0;
            re_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            win_q    <= win_d;
            ready_q  <= ready_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            lock_x_q <= lock_x_d;
            lock_y_q <= lock_y_d;
            lv_q     <= lv_d;
            pe_q     <= pe_d;
            re_q     <= re_d;
        end
    end

    assign locked_x      = lock_x_q;
    assign locked_y      = lock_y_q;
    assign locked_valid  = lv_q;
    assign press_event   = pe_q;
    assign release_event = re_q;

endmodule

// File: tb/tb_touch_frame_lock.sv
// tb_touch_frame_lock
//   Directed scenarios plus randomized sample/frame traffic, compared each
//   cycle against a behavioural model of debounce, averaging and frame lock.
module tb_touch_frame_lock;

    logic        cclk = 1'b0;
    logic        reset = 1'b1;
    logic        touch_valid = 1'b0;
    logic [11:0] touch_x = '0, touch_y = '0, touch_z = '0;
    logic        new_frame = 1'b0;
    logic [11:0] locked_x, locked_y;
    logic        locked_valid, press_event, release_event;

    touch_frame_lock dut (
        .cclk          (cclk),
        .reset         (reset),
        .touch_valid   (touch_valid),
        .touch_x       (touch_x),
        .touch_y       (touch_y),
        .touch_z       (touch_z),
        .new_frame     (new_frame),
        .locked_x      (locked_x),
        .locked_y      (locked_y),
        .locked_valid  (locked_valid),
        .press_event   (press_event),
        .release_event (release_event)
    );

    always #5 cclk = ~cclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: debounced "down" flag with a streak of opposing
    // samples, a queue of pressed samples forming the averaging window.
    bit m_down, m_ready, m_lv, m_pe, m_re;
    int m_streak, m_pend_x, m_pend_y, m_lx, m_ly;
    int qx[$], qy[$];

    function automatic int scr(input int avg, input int off, input int sh, input int mx);
        int d;
        d = avg - off;
        if (d < 0) d = 0;
        d = d >> sh;
        return (d > mx) ? mx : d;
    endfunction

    task automatic model_reset();
        m_down = 0; m_ready = 0; m_streak = 0;
        m_pend_x = 0; m_pend_y = 0;
        m_lx = 1000; m_ly = 1000; m_lv = 0; m_pe = 0; m_re = 0;
        qx.delete(); qy.delete();
    endtask

    task automatic model_sample(input int x, input int y, input bit p);
        int sx, sy;
        if (p) begin
            if (m_down) m_streak = 0;
            else begin
                m_streak++;
                if (m_streak >= 4) begin m_down = 1; m_streak = 0; end
            end
            qx.push_back(x); qy.push_back(y);
            if (qx.size() == 4) begin
                sx = 0; sy = 0;
                foreach (qx[i]) begin sx += qx[i]; sy += qy[i]; end
                m_pend_x = scr(sx / 4, 150, 3, 479);
                m_pend_y = scr(sy / 4, 300, 4, 271);
                m_ready = 1;
                qx.delete(); qy.delete();
            end
        end else begin
            qx.delete(); qy.delete();
            if (!m_down) m_streak = 0;
            else begin
                m_streak++;
                if (m_streak >= 4) begin m_down = 0; m_streak = 0; m_ready = 0; end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_lx"}, 32'(locked_x), 32'(m_lx));
        check({tag, "_ly"}, 32'(locked_y), 32'(m_ly));
        check({tag, "_lv"}, 32'(locked_valid), 32'(m_lv));
        check({tag, "_pe"}, 32'(press_event), 32'(m_pe));
        check({tag, "_re"}, 32'(release_event), 32'(m_re));
    endtask

    task automatic step(input string tag, input bit v, input int x, input int y, input int z, input bit nf);
        bit t;
        touch_valid = v; touch_x = 12'(x); touch_y = 12'(y); touch_z = 12'(z); new_frame = nf;
        m_pe = 0; m_re = 0;
        if (nf) begin
            t = m_down && m_ready;
            m_pe = t && !m_lv;
            m_re = !t && m_lv;
            m_lv = t;
            m_lx = t ? m_pend_x : 1000;
            m_ly = t ? m_pend_y : 1000;
        end
        if (v) model_sample(x, y, z >= 256);
        @(posedge cclk); #1;
        touch_valid = 0; new_frame = 0;
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset = 1; touch_valid = 0; new_frame = 0;
        @(posedge cclk); @(posedge cclk); #1;
        model_reset();
        compare_all("reset");
        reset = 0;
    endtask

    task automatic frame(input string tag);
        step(tag, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit mode;
        int z;
        // T1
        do_reset();
        check("T1_lx", 32'(locked_x), 1000);
        // T2
        for (int i = 0; i < 4; i++) step("T2s", 1, 950, 2000, 'h400, 0);
        frame("T2f");
        check("T2_lx", 32'(locked_x), 100);
        check("T2_ly", 32'(locked_y), 106);
        check("T2_lv", 32'(locked_valid), 1);
        check("T2_pe", 32'(press_event), 1);
        step("T2idle", 0, 0, 0, 0, 0);
        check("T2_pe_drop", 32'(press_event), 0);
        // T3
        for (int i = 0; i < 4; i++) step("T3s", 1, 100, 2000, 'h400, 0);
        frame("T3f");
        check("T3_lo", 32'(locked_x), 0);
        for (int i = 0; i < 4; i++) step("T3s2", 1, 4095, 2000, 'h400, 0);
        frame("T3f2");
        check("T3_hi", 32'(locked_x), 479);
        // T4
        do_reset();
        for (int i = 0; i < 3; i++) step("T4a", 1, 950, 2000, 'h400, 0);
        step("T4z", 1, 950, 2000, 0, 0);
        for (int i = 0; i < 3; i++) step("T4b", 1, 950, 2000, 'h400, 0);
        frame("T4f");
        check("T4_lv", 32'(locked_valid), 0);
        check("T4_lx", 32'(locked_x), 1000);
        // T5: one more pressed sample completes both debounce and window
        step("T5p", 1, 950, 2000, 'h400, 0);
        frame("T5f0");
        check("T5_lx0", 32'(locked_x), 100);
        for (int i = 0; i < 3; i++) step("T5z", 1, 0, 0, 0, 0);
        step("T5p2", 1, 4095, 4095, 'h400, 0);
        frame("T5f1");
        check("T5_lv1", 32'(locked_valid), 1);
        check("T5_lx1", 32'(locked_x), 100);
        for (int i = 0; i < 4; i++) step("T5z2", 1, 0, 0, 0, 0);
        frame("T5f2");
        check("T5_lx2", 32'(locked_x), 1000);
        check("T5_re", 32'(release_event), 1);
        step("T5idle", 0, 0, 0, 0, 0);
        check("T5_re_drop", 32'(release_event), 0);
        // T6
        do_reset();
        for (int i = 0; i < 4; i++) step("T6a", 1, 800, 2000, 'h400, 0);
        frame("T6f0");
        check("T6_lx0", 32'(locked_x), 81);
        for (int i = 0; i < 3; i++) step("T6b", 1, 1200, 2000, 'h400, 0);
        step("T6co", 1, 1200, 2000, 'h400, 1);
        check("T6_lx1", 32'(locked_x), 81);
        frame("T6f2");
        check("T6_lx2", 32'(locked_x), 131);

        // Random traffic with long pressed/unpressed runs and threshold edges
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            case ($urandom_range(0, 9))
                0:       z = mode ? 256 : 255;
                1:       z = mode ? 4095 : 0;
                default: z = mode ? $urandom_range(256, 4095) : $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 19) == 0) z = $urandom_range(0, 4095);
            step("rnd", $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(100, 1200),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(250, 1500),
                 z, $urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
